// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet controller.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_timer.sv
// Inter-byte watchdog: counts idle clocks while enabled and flags expiry on the
// last allowed idle clock.
module uart_pkt_timer #(
    parameter int g_TIMEOUT_CLKS = 208340
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Expire
);

    localparam int CW = $clog2(g_TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] LIMIT = CW'(g_TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_Clr)
            cnt_d = '0;
        else if (i_En && cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // A byte on the expiry cycle clears the counter and suppresses expiry.
    assign o_Expire = i_En && !i_Clr && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frame parser SYNC|CMD|LEN|PAYLOAD|CHK behind a UART byte receiver.
// Optional inter-byte watchdog enabled by defining UART_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] g_SYNC_BYTE    = SYNC_DEFAULT,
    parameter int         g_MAX_LEN      = 16,
    parameter int         g_TIMEOUT_CLKS = 208340,
    localparam int        AW             = (g_MAX_LEN > 1) ? $clog2(g_MAX_LEN) : 1
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte,
    output logic          o_Wr_En,
    output logic [AW-1:0] o_Wr_Addr,
    output logic [7:0]    o_Wr_Data,
    output logic [7:0]    o_Pkt_Cmd,
    output logic [7:0]    o_Pkt_Len,
    output logic          o_Pkt_Done,
    output logic          o_Pkt_Err,
    output logic [1:0]    o_Err_Code,
    output logic          o_Busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(g_MAX_LEN);

    state_e        state_q, state_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    len_q, len_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          tmo_expire;

`ifdef UART_PKT_TIMEOUT_EN
    uart_pkt_timer #(
        .g_TIMEOUT_CLKS(g_TIMEOUT_CLKS)
    ) u_timer (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clr   (i_RX_DV || (state_q == ST_IDLE)),
        .i_En    (state_q != ST_IDLE),
        .o_Expire(tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;

        if (i_RX_DV) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_RX_Byte == g_SYNC_BYTE)
                        state_d = ST_CMD;
                end
                ST_CMD: begin
                    cmd_d   = i_RX_Byte;
                    sum_d   = i_RX_Byte;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    len_d = i_RX_Byte;
                    sum_d = sum_q + i_RX_Byte;
                    idx_d = '0;
                    if (i_RX_Byte > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_IDLE;
                    end else if (i_RX_Byte == 8'h00) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = i_RX_Byte;
                    sum_d     = sum_q + i_RX_Byte;
                    if (8'(idx_q) == len_q - 8'd1)
                        state_d = ST_CHK;
                    else
                        idx_d = idx_q + 1'b1;
                end
                ST_CHK: begin
                    if (i_RX_Byte == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_expire) begin
            err_d   = 1'b1;
            code_d  = ERR_TMO;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            sum_q     <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign o_Wr_En    = wr_en_q;
    assign o_Wr_Addr  = wr_addr_q;
    assign o_Wr_Data  = wr_data_q;
    assign o_Pkt_Cmd  = cmd_q;
    assign o_Pkt_Len  = len_q;
    assign o_Pkt_Done = done_q;
    assign o_Pkt_Err  = err_q;
    assign o_Err_Code = code_q;
    assign o_Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl; covers both watchdog builds.
module tb_uart_rx_pkt_ctrl;

    localparam int MAXL = 16;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       dv;
    logic [7:0] rx_byte;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] pkt_cmd;
    logic [7:0] pkt_len;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_pkt_ctrl #(
        .g_SYNC_BYTE   (8'hA5),
        .g_MAX_LEN     (MAXL),
        .g_TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_l),
        .i_RX_DV   (dv),
        .i_RX_Byte (rx_byte),
        .o_Wr_En   (wr_en),
        .o_Wr_Addr (wr_addr),
        .o_Wr_Data (wr_data),
        .o_Pkt_Cmd (pkt_cmd),
        .o_Pkt_Len (pkt_len),
        .o_Pkt_Done(pkt_done),
        .o_Pkt_Err (pkt_err),
        .o_Err_Code(err_code),
        .o_Busy    (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: running totals only, read by the stimulus as deltas.
    int done_tot = 0;
    int err_tot  = 0;
    int both_tot = 0;
    int wr_a[$];
    int wr_d[$];

    always @(negedge clk) begin
        if (pkt_done) done_tot++;
        if (pkt_err)  err_tot++;
        if (pkt_done && pkt_err) both_tot++;
        if (wr_en) begin
            wr_a.push_back(int'(wr_addr));
            wr_d.push_back(int'(wr_data));
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        dv      = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int d0, e0, w0;

    task automatic mark();
        d0 = done_tot;
        e0 = err_tot;
        w0 = wr_a.size();
    endtask

    task automatic chk_wr(input string tag, input int k, input int a, input int d);
        if (w0 + k < wr_a.size()) begin
            chk({tag, "_addr"}, wr_a[w0+k], a);
            chk({tag, "_data"}, wr_d[w0+k], d);
        end else begin
            chk({tag, "_missing"}, wr_a.size(), w0 + k + 1);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_wr_en"}, wr_en,    0);
        chk({tag, "_addr"},  wr_addr,  0);
        chk({tag, "_data"},  wr_data,  0);
        chk({tag, "_cmd"},   pkt_cmd,  0);
        chk({tag, "_len"},   pkt_len,  0);
        chk({tag, "_done"},  pkt_done, 0);
        chk({tag, "_err"},   pkt_err,  0);
        chk({tag, "_code"},  err_code, 0);
        chk({tag, "_busy"},  busy,     0);
    endtask

    task automatic frame1();
        send(8'hA5);
        chk("t1_busy_mid", busy, 1);
        send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h45);
        idle(2);
    endtask

    initial begin
        rst_l   = 1'b0;
        dv      = 1'b0;
        rx_byte = 8'h00;
        idle(3);
        chk_idle_outs("reset");
        rst_l = 1'b1;
        idle(2);

        // Test 1: basic good frame.
        mark();
        frame1();
        chk("t1_nwr",  wr_a.size() - w0, 2);
        chk_wr("t1_w0", 0, 0, 8'h11);
        chk_wr("t1_w1", 1, 1, 8'h22);
        chk("t1_done", done_tot - d0, 1);
        chk("t1_err",  err_tot - e0, 0);
        chk("t1_cmd",  pkt_cmd, 8'h10);
        chk("t1_len",  pkt_len, 8'h02);
        chk("t1_code", err_code, 0);
        chk("t1_busy", busy, 0);

        // Test 2: leading junk ignored.
        mark();
        send(8'h00); send(8'hFF); send(8'h3C);
        chk("t2_busy_junk", busy, 0);
        frame1();
        chk("t2_nwr",  wr_a.size() - w0, 2);
        chk_wr("t2_w1", 1, 1, 8'h22);
        chk("t2_done", done_tot - d0, 1);
        chk("t2_err",  err_tot - e0, 0);

        // Test 3: zero-length frame, CMD=22 so CHK=22.
        mark();
        send(8'hA5); send(8'h22); send(8'h00); send(8'h22);
        idle(2);
        chk("t3_nwr",  wr_a.size() - w0, 0);
        chk("t3_done", done_tot - d0, 1);
        chk("t3_len",  pkt_len, 8'h00);

        // Test 4: LEN above max, then recovery.
        mark();
        send(8'hA5); send(8'h10); send(8'h11);
        chk("t4_err_pulse", pkt_err, 1);
        chk("t4_code", err_code, 2'b01);
        chk("t4_busy", busy, 0);
        chk("t4_len",  pkt_len, 8'h11);
        send(8'hA5);
        chk("t4_resync", busy, 1);
        send(8'h10); send(8'h01); send(8'h33); send(8'h44);
        idle(2);
        chk("t4_done", done_tot - d0, 1);
        chk("t4_errs", err_tot - e0, 1);
        chk("t4_code_held", err_code, 2'b01);

        // Test 5: bad checksum.
        mark();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h46);
        chk("t5_err_pulse", pkt_err, 1);
        chk("t5_code", err_code, 2'b10);
        idle(2);
        chk("t5_nwr",  wr_a.size() - w0, 2);
        chk("t5_done", done_tot - d0, 0);

        // SYNC value as payload data.
        mark();
        send(8'hA5); send(8'h10); send(8'h01); send(8'hA5); send(8'hB6);
        idle(2);
        chk_wr("sync_data", 0, 0, 8'hA5);
        chk("sync_done", done_tot - d0, 1);

        // LEN equal to the maximum: 16 bytes 00..0F, sum 01+10+78 = 89.
        mark();
        send(8'hA5); send(8'h01); send(8'(MAXL));
        for (int i = 0; i < MAXL; i++) send(8'(i));
        send(8'h89);
        idle(2);
        chk("max_nwr",  wr_a.size() - w0, MAXL);
        chk_wr("max_last", MAXL - 1, MAXL - 1, MAXL - 1);
        chk("max_done", done_tot - d0, 1);
        chk("max_err",  err_tot - e0, 0);

        // Test 6: silence after CMD.
        mark();
        send(8'hA5); send(8'h10);
`ifdef UART_PKT_TIMEOUT_EN
        idle(TMO - 1);
        chk("t6_early_err", pkt_err, 0);
        chk("t6_early_busy", busy, 1);
        idle(1);
        chk("t6_tmo_err", pkt_err, 1);
        chk("t6_tmo_code", err_code, 2'b11);
        chk("t6_tmo_busy", busy, 0);
        mark();
        send(8'hA5); send(8'h10);
`else
        idle(3 * TMO);
        chk("t6_busy_wait", busy, 1);
        chk("t6_no_err", err_tot - e0, 0);
        mark();
`endif
        // Mid-frame reset discards the partial frame.
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        chk_idle_outs("midrst");
        rst_l = 1'b1;
        idle(2);
        chk("midrst_pulses", (done_tot - d0) + (err_tot - e0), 0);

        mark();
        frame1();
        chk("post_rst_done", done_tot - d0, 1);
        chk("post_rst_nwr", wr_a.size() - w0, 2);
        chk("never_both", both_tot, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
